// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch with a direct-mapped I-cache, line refill FSM and an instruction queue
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable; low holds all state)
//   mem_req_o / mem_addr_o / mem_avail_i / mem_word_valid_i / mem_word_i : line refill interface
//   pred_pc_o / pred_inst_o : current fetch PC and its cached instruction (0 on miss)
//   pred_taken_i / pred_imm_i / pred_is_jalr_i : predictor verdict for pred_pc_o
//   disp_valid_o / disp_inst_o / disp_pc_o / disp_rollback_pc_o / disp_pred_taken_o / disp_full_i : dispatch
//   rob_rollback_i / rob_target_pc_i / rob_jalr_commit_i : flush, redirect and JALR resolution
module inst_fetch_unit #(
    parameter int          IQ_DEPTH     = 8,
    parameter int          ICACHE_LINES = 64,
    parameter int          LINE_WORDS   = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_avail_i,
    input  logic        mem_word_valid_i,
    input  logic [31:0] mem_word_i,
    output logic [31:0] pred_pc_o,
    output logic [31:0] pred_inst_o,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_imm_i,
    input  logic        pred_is_jalr_i,
    output logic        disp_valid_o,
    output logic [31:0] disp_inst_o,
    output logic [31:0] disp_pc_o,
    output logic [31:0] disp_rollback_pc_o,
    output logic        disp_pred_taken_o,
    input  logic        disp_full_i,
    input  logic        rob_rollback_i,
    input  logic [31:0] rob_target_pc_i,
    input  logic        rob_jalr_commit_i
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(ICACHE_LINES);
    localparam int TW = 30 - WB - IB;
    localparam int QB = $clog2(IQ_DEPTH);
    localparam int CW = WB > 0 ? WB : 1;
    localparam int XW = IB > 0 ? IB : 1;
    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
    function automatic logic [XW-1:0] idx_of(input logic [31:0] a);
        return IB > 0 ? XW'(a >> (2 + WB)) : '0;
    endfunction
    function automatic logic [CW-1:0] word_of(input logic [31:0] a);
        return WB > 0 ? CW'(a >> 2) : '0;
    endfunction
    function automatic logic [TW-1:0] tag_of(input logic [31:0] a);
        return TW'(a >> (2 + WB + IB));
    endfunction
    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [31:0]         lbuf_q [LINE_WORDS];
    logic [ICACHE_LINES-1:0] valid_q;
    logic [TW-1:0]       tag_q [ICACHE_LINES];
    logic [31:0]         data_q [ICACHE_LINES][LINE_WORDS];
    logic [31:0]         pc_q, pc_d;
    logic                halt_q, halt_d;
    logic [QB-1:0]       head_q, tail_q;
    logic [QB:0]         count_q, count_d;
    logic [31:0]         q_inst_q [IQ_DEPTH];
    logic [31:0]         q_pc_q [IQ_DEPTH];
    logic                q_taken_q [IQ_DEPTH];
    logic [XW-1:0]       idx, fidx;
    logic [CW-1:0]       wrd;
    logic                hit, ins, lau, last;
    assign idx  = idx_of(pc_q);
    assign wrd  = word_of(pc_q);
    assign fidx = idx_of(mem_addr_o);
    assign hit  = valid_q[idx] && tag_q[idx] == tag_of(pc_q);
    assign ins  = !rob_rollback_i && hit && !halt_q && count_q != (QB+1)'(IQ_DEPTH);
    assign lau  = !rob_rollback_i && !disp_full_i && count_q != '0;
    assign last = state_q == FILL && mem_word_valid_i && cnt_q == CW'(LINE_WORDS - 1);
    assign pc_d    = ins ? pc_q + (pred_taken_i ? pred_imm_i : 32'd4) : pc_q;
    assign count_d = count_q + (QB+1)'(ins) - (QB+1)'(lau);
    // A JALR insert always wins: while halted no insert can coincide with a commit.
    assign halt_d  = (ins && pred_is_jalr_i) || (halt_q && !rob_jalr_commit_i);
    assign pred_pc_o   = pc_q;
    assign pred_inst_o = hit ? data_q[idx][wrd] : '0;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            valid_q            <= '0;
            mem_req_o          <= 1'b0;
            mem_addr_o         <= '0;
            pc_q               <= RESET_PC;
            halt_q             <= 1'b0;
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            disp_valid_o       <= 1'b0;
            disp_inst_o        <= '0;
            disp_pc_o          <= '0;
            disp_rollback_pc_o <= '0;
            disp_pred_taken_o  <= 1'b0;
        end else if (rdy_in) begin
            // The refill runs independently of rollback so a started line is always installed.
            case (state_q)
                IDLE: if (!hit && mem_avail_i) begin
                    state_q    <= REQ;
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= pc_q & ~32'(LINE_WORDS * 4 - 1);
                end
                REQ: begin
                    state_q <= FILL;
                    cnt_q   <= '0;
                end
                FILL: if (mem_word_valid_i) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q       <= IDLE;
                        mem_req_o     <= 1'b0;
                        valid_q[fidx] <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (rob_rollback_i) begin
                pc_q               <= rob_target_pc_i;
                halt_q             <= 1'b0;
                head_q             <= '0;
                tail_q             <= '0;
                count_q            <= '0;
                disp_valid_o       <= 1'b0;
                disp_inst_o        <= '0;
                disp_pc_o          <= '0;
                disp_rollback_pc_o <= '0;
                disp_pred_taken_o  <= 1'b0;
            end else begin
                pc_q               <= pc_d;
                halt_q             <= halt_d;
                count_q            <= count_d;
                tail_q             <= ins ? tail_q + 1'b1 : tail_q;
                head_q             <= lau ? head_q + 1'b1 : head_q;
                disp_valid_o       <= lau;
                disp_inst_o        <= lau ? q_inst_q[head_q] : '0;
                disp_pc_o          <= lau ? q_pc_q[head_q] : '0;
                disp_rollback_pc_o <= lau ? q_pc_q[head_q] + 32'd4 : '0;
                disp_pred_taken_o  <= lau && q_taken_q[head_q];
            end
        end
    end
    // Storage arrays carry no reset; the valid bits alone decide whether contents are used.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (state_q == FILL && mem_word_valid_i) lbuf_q[cnt_q] <= mem_word_i;
            if (last) begin
                tag_q[fidx] <= tag_of(mem_addr_o);
                for (int w = 0; w < LINE_WORDS; w++)
                    data_q[fidx][w] <= (w == LINE_WORDS - 1) ? mem_word_i : lbuf_q[w];
            end
            if (ins) begin
                q_inst_q[tail_q]  <= pred_inst_o;
                q_pc_q[tail_q]    <= pc_q;
                q_taken_q[tail_q] <= pred_taken_i;
            end
        end
    end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter IQ_DEPTH, default 8: instruction queue entries; power of two, at least 2.
REQ-002 Parameter ICACHE_LINES, default 64: direct-mapped I-cache lines; power of two.
REQ-003 Parameter LINE_WORDS, default 4: 32-bit words per line; power of two, at least 1.
REQ-004 Parameter RESET_PC, default 32'h0: PC after reset.
REQ-005 clk_in  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_in  in  1  reset, asynchronous, active-high.
REQ-007 rdy_in  in  1  global enable; low = hold all state.
REQ-008 mem_req_o  out  1  refill request, held high until the line completes.
REQ-009 mem_addr_o  out  32  line-aligned refill address.
REQ-010 mem_avail_i  in  1  memory controller can accept a request.
REQ-011 mem_word_valid_i  in  1  one refill word is present this cycle.
REQ-012 mem_word_i  in  32  refill word, delivered in ascending address order.
REQ-013 pred_pc_o  out  32  current fetch PC, combinational.
REQ-014 pred_inst_o  out  32  cached instruction at the fetch PC on a hit, else 0; combinational.
REQ-015 pred_taken_i / pred_imm_i / pred_is_jalr_i  in  1/32/1  predictor verdict for pred_pc_o: taken flag, PC offset, JALR flag.
REQ-016 disp_valid_o  out  1  dispatch strobe.
REQ-017 disp_inst_o / disp_pc_o / disp_rollback_pc_o  out  32 each  instruction, its PC, and its PC+4.
REQ-018 disp_pred_taken_o  out  1  predicted-taken flag for the dispatched instruction.
REQ-019 disp_full_i  in  1  dispatcher cannot accept this cycle.
REQ-020 rob_rollback_i / rob_target_pc_i  in  1/32  mispredict flush and redirect target.
REQ-021 rob_jalr_commit_i  in  1  an outstanding JALR has committed.

Function
REQ-022 Address split: offset = pc[1:0], ignored; word = next log2(LINE_WORDS) bits; index = next log2(ICACHE_LINES) bits; tag = the remaining upper bits.
REQ-023 Hit: line[index] valid AND stored tag == tag(pc); anything else is a miss.
REQ-024 Refill FSM IDLE->REQ: taken on miss AND mem_avail_i; latches mem_addr_o = pc with word and offset bits zeroed, asserts mem_req_o.
REQ-025 REQ->FILL: taken the cycle after entering REQ.
REQ-026 FILL: each mem_word_valid_i writes word[cnt] into a line buffer and increments cnt.
REQ-027 FILL->IDLE: on the LINE_WORDS-th word, write tag and data and set valid in the same edge; deassert mem_req_o.
REQ-028 A line is never marked valid while partially filled.
REQ-029 Rollback during REQ/FILL does not abort the refill; the line is still installed.
REQ-030 Queue: circular FIFO, IQ_DEPTH entries, log2(IQ_DEPTH)-bit head and tail pointers wrapping to 0, count of log2(IQ_DEPTH)+1 bits.
REQ-031 Insert: hit AND count < IQ_DEPTH AND !halt; enqueues {inst, pc, pred_taken_i, pc+4}.
REQ-032 On insert: pc <= pc + pred_imm_i if pred_taken_i, else pc + 4 (32-bit wrap).
REQ-033 On insert of a JALR (pred_is_jalr_i): set halt.
REQ-034 Halt clears on rob_jalr_commit_i or rob_rollback_i.
REQ-035 Launch: !disp_full_i AND count != 0; registers the head entry onto the disp_* outputs, disp_valid_o = 1 for exactly that cycle, head advances.
REQ-036 No launch in a cycle: disp_valid_o = 0 and all disp_* data = 0.
REQ-037 Insert and launch in the same cycle: count unchanged.
REQ-038 Queue full (count = IQ_DEPTH): no insert, even if a launch occurs that cycle.
REQ-039 Rollback has priority over insert, launch and jalr commit: head, tail and count <= 0; pc <= rob_target_pc_i; halt <= 0; disp_valid_o <= 0.
REQ-040 Outputs launch one cycle after insert at the earliest; no same-cycle bypass.
REQ-041 rdy_in = 0: no state changes, including the refill counter; mem_word_valid_i is ignored.

Reset
REQ-042 rst_in high asynchronously clears: all cache valid bits, FSM to IDLE, cnt, queue pointers and count, halt.
REQ-043 During reset: pc <= RESET_PC; mem_req_o = 0, mem_addr_o = 0, disp_valid_o = 0, all disp_* = 0.
REQ-044 Reset asserted mid-FILL discards the partial line.

Verification
REQ-045 Cold start, RESET_PC = 0, LINE_WORDS = 4: mem_req_o rises with mem_addr_o = 0; after 4 words (addi x1,x0,1 ...) line 0 becomes valid; first disp_valid_o carries disp_pc_o = 0, disp_rollback_pc_o = 4.
REQ-046 Taken branch at 0x10 with pred_imm_i = 0xFFFFFFF0: next enqueued pc = 0x0; disp_pred_taken_o = 1 for the 0x10 entry.
REQ-047 Hold disp_full_i high with the cache warm: count reaches IQ_DEPTH = 8 and stops; release it: 8 consecutive disp_valid_o pulses in FIFO order, pointers wrap correctly.
REQ-048 JALR at 0x20: nothing after 0x20 is enqueued until rob_jalr_commit_i; fetch then resumes at the predicted pc.
REQ-049 rob_rollback_i with target 0x400 during FILL of line 0x100: queue empties; the 0x100 line still becomes valid; a new refill at 0x400 follows.
REQ-050 Assert rst_in asynchronously mid-FILL: mem_req_o and disp_valid_o drop before the next edge; after release, the refill restarts from RESET_PC.
